// File: rtl/primitive_pkg.sv
// Shared helpers for the primitive_* delay-line family: width math, modulo
// pointer arithmetic and tap-select classification.
package primitive_pkg;

    typedef enum logic [1:0] {
        TAP_FWD   = 2'd0,
        TAP_NORM  = 2'd1,
        TAP_CLAMP = 2'd2
    } tap_sel_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Operands are already reduced below len, so one conditional add suffices
    // and no power-of-two truncation is assumed.
    function automatic int unsigned mod_sub(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned len);
        return (a >= b) ? (a - b) : (a + len - b);
    endfunction

endpackage

// File: rtl/primitive_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with an
// optional write-first bypass when both ports address the same slot.
module primitive_sdp_ram
    import primitive_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned AW          = clog2(DEPTH),
    parameter bit          WRITE_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            if (WRITE_FIRST && i_we && (i_raddr == i_waddr)) begin
                r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/primitive_sr_bram_vtap.sv
// BRAM-backed delay line with runtime tap select, fixed last-stage output,
// per-slot write masking and blanking of slots not written since reset.
module primitive_sr_bram_vtap
    import primitive_pkg::*;
#(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned LENGTH = 32,
    localparam int unsigned AW     = clog2(LENGTH),
    localparam int unsigned TW     = clog2(LENGTH + 1)
) (
    input  logic             i_EMUCLK,
    input  logic             i_RST,
    input  logic             i_CEN_n,
    input  logic             i_CNTRRST,
    input  logic             i_WR,
    input  logic [WIDTH-1:0] i_D,
    input  logic [TW-1:0]    i_TAP,
    output logic [WIDTH-1:0] o_Q_TAP,
    output logic [WIDTH-1:0] o_Q_LAST,
    output logic [AW-1:0]    o_SLOT,
    output logic             o_PRIMED
);

    localparam logic [AW-1:0] LAST_SLOT = AW'(LENGTH - 1);
    localparam logic [TW-1:0] TAP_MAX   = TW'(LENGTH);

    logic             w_en;
    logic [AW-1:0]    w_addr;
    logic [AW-1:0]    w_next_wp;
    tap_sel_e         w_tap_sel;
    logic [AW-1:0]    w_tap_dist;
    logic [AW-1:0]    w_tap_addr;
    logic [AW-1:0]    w_last_addr;
    logic             w_tap_vld;
    logic             w_last_vld;
    logic [WIDTH-1:0] w_tap_q;
    logic [WIDTH-1:0] w_last_q;

    logic [AW-1:0]     r_wp;
    logic [TW-1:0]     r_fill;
    logic [LENGTH-1:0] r_vld;
    logic              r_tap_vld;
    logic              r_last_vld;

    assign w_en      = ~i_CEN_n;
    assign w_addr    = i_CNTRRST ? '0 : r_wp;
    assign w_next_wp = (w_addr == LAST_SLOT) ? '0 : w_addr + AW'(1);

    always_comb begin
        if (i_TAP == '0) begin
            w_tap_sel = TAP_FWD;
        end else if (i_TAP > TAP_MAX) begin
            w_tap_sel = TAP_CLAMP;
        end else begin
            w_tap_sel = TAP_NORM;
        end

        case (w_tap_sel)
            TAP_FWD:   w_tap_dist = '0;
            TAP_CLAMP: w_tap_dist = LAST_SLOT;
            default:   w_tap_dist = AW'(i_TAP - TW'(1));
        endcase
    end

    assign w_tap_addr  = AW'(mod_sub(32'(w_addr), 32'(w_tap_dist), LENGTH));
    assign w_last_addr = AW'(mod_sub(32'(w_addr), LENGTH - 1, LENGTH));

    // The tap may read the slot being written this edge, so its valid bit
    // must follow the same write-first rule as the data bypass.
    assign w_tap_vld  = (i_WR && (w_tap_addr == w_addr)) ? 1'b1 : r_vld[w_tap_addr];
    assign w_last_vld = r_vld[w_last_addr];

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            r_wp       <= '0;
            r_fill     <= '0;
            r_vld      <= '0;
            r_tap_vld  <= 1'b0;
            r_last_vld <= 1'b0;
        end else if (w_en) begin
            r_wp <= w_next_wp;
            if (r_fill != TAP_MAX) begin
                r_fill <= r_fill + TW'(1);
            end
            if (i_WR) begin
                r_vld[w_addr] <= 1'b1;
            end
            r_tap_vld  <= w_tap_vld;
            r_last_vld <= w_last_vld;
        end
    end

    primitive_sdp_ram #(
        .WIDTH       (WIDTH),
        .DEPTH       (LENGTH),
        .AW          (AW),
        .WRITE_FIRST (1'b1)
    ) u_ram_tap (
        .i_clk   (i_EMUCLK),
        .i_en    (w_en),
        .i_we    (i_WR),
        .i_waddr (w_addr),
        .i_wdata (i_D),
        .i_raddr (w_tap_addr),
        .o_rdata (w_tap_q)
    );

    primitive_sdp_ram #(
        .WIDTH       (WIDTH),
        .DEPTH       (LENGTH),
        .AW          (AW),
        .WRITE_FIRST (1'b0)
    ) u_ram_last (
        .i_clk   (i_EMUCLK),
        .i_en    (w_en),
        .i_we    (i_WR),
        .i_waddr (w_addr),
        .i_wdata (i_D),
        .i_raddr (w_last_addr),
        .o_rdata (w_last_q)
    );

    // RAM read registers have no reset; the fabric valid flags gate them so
    // the outputs still clear asynchronously.
    assign o_Q_TAP  = r_tap_vld  ? w_tap_q  : '0;
    assign o_Q_LAST = r_last_vld ? w_last_q : '0;
    assign o_SLOT   = r_wp;
    assign o_PRIMED = (r_fill == TAP_MAX);

endmodule

// File: tb/tb_primitive_sr_bram_vtap.sv
// Directed bench for primitive_sr_bram_vtap: LENGTH=32 instance for the main
// behaviours plus a LENGTH=24 instance for non-power-of-two wrap.
module tb_primitive_sr_bram_vtap;

    logic       clk;
    logic       rst;

    logic       a_cen_n, a_cntrrst, a_wr;
    logic [7:0] a_d;
    logic [5:0] a_tap;
    logic [7:0] a_qtap, a_qlast;
    logic [4:0] a_slot;
    logic       a_primed;

    logic       b_cen_n, b_cntrrst, b_wr;
    logic [7:0] b_d;
    logic [4:0] b_tap;
    logic [7:0] b_qtap, b_qlast;
    logic [4:0] b_slot;
    logic       b_primed;

    int unsigned n_cmp;
    int unsigned n_bad;

    typedef struct {
        logic [5:0] tap;
        logic       wr;
        logic [7:0] d;
        logic [7:0] e_tap;
        logic [7:0] e_last;
        logic [4:0] e_slot;
    } vec_t;

    vec_t vecs[9];

    primitive_sr_bram_vtap #(.WIDTH(8), .LENGTH(32)) u_dut_a (
        .i_EMUCLK  (clk),
        .i_RST     (rst),
        .i_CEN_n   (a_cen_n),
        .i_CNTRRST (a_cntrrst),
        .i_WR      (a_wr),
        .i_D       (a_d),
        .i_TAP     (a_tap),
        .o_Q_TAP   (a_qtap),
        .o_Q_LAST  (a_qlast),
        .o_SLOT    (a_slot),
        .o_PRIMED  (a_primed)
    );

    primitive_sr_bram_vtap #(.WIDTH(8), .LENGTH(24)) u_dut_b (
        .i_EMUCLK  (clk),
        .i_RST     (rst),
        .i_CEN_n   (b_cen_n),
        .i_CNTRRST (b_cntrrst),
        .i_WR      (b_wr),
        .i_D       (b_d),
        .i_TAP     (b_tap),
        .o_Q_TAP   (b_qtap),
        .o_Q_LAST  (b_qlast),
        .o_SLOT    (b_slot),
        .o_PRIMED  (b_primed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] et, input logic [7:0] el,
                         input logic [4:0] es, input logic ep);
        chk({tag, ".tap"},    32'(a_qtap),   32'(et));
        chk({tag, ".last"},   32'(a_qlast),  32'(el));
        chk({tag, ".slot"},   32'(a_slot),   32'(es));
        chk({tag, ".primed"}, 32'(a_primed), 32'(ep));
    endtask

    initial begin
        logic [7:0] v;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{6'd0,  1'b1, 8'h47, 8'h47, 8'h28, 5'd7};
        vecs[1] = '{6'd1,  1'b1, 8'h48, 8'h48, 8'h29, 5'd8};
        vecs[2] = '{6'd40, 1'b1, 8'h49, 8'h2A, 8'h2A, 5'd9};
        vecs[3] = '{6'd32, 1'b1, 8'h4A, 8'h2B, 8'h2B, 5'd10};
        vecs[4] = '{6'd2,  1'b1, 8'h4B, 8'h4A, 8'h2C, 5'd11};
        vecs[5] = '{6'd63, 1'b1, 8'h4C, 8'h2D, 8'h2D, 5'd12};
        vecs[6] = '{6'd31, 1'b1, 8'h4D, 8'h2F, 8'h2E, 5'd13};
        vecs[7] = '{6'd1,  1'b0, 8'hFF, 8'h2E, 8'h2F, 5'd14};
        vecs[8] = '{6'd2,  1'b1, 8'h4F, 8'h2E, 8'h30, 5'd15};

        rst = 1'b1;
        a_cen_n = 1'b0; a_cntrrst = 1'b0; a_wr = 1'b0; a_d = '0; a_tap = 6'd5;
        b_cen_n = 1'b1; b_cntrrst = 1'b0; b_wr = 1'b0; b_d = '0; b_tap = 5'd5;
        #1;
        chk_a("reset", 8'h00, 8'h00, 5'd0, 1'b0);
        do_reset();

        // Reset blanking: nothing written, outputs stay 0; primed after 32 edges.
        for (int k = 1; k <= 40; k++) begin
            step();
            chk_a($sformatf("blank[%0d]", k), 8'h00, 8'h00, 5'(k % 32), k >= 32);
        end

        // Tap delay with ramp across the wrap.
        do_reset();
        a_wr = 1'b1; a_tap = 6'd5;
        for (int e = 0; e < 70; e++) begin
            a_d = 8'(e + 1);
            step();
            chk_a($sformatf("ramp[%0d]", e),
                  (e >= 4)  ? 8'(e - 3)  : 8'h00,
                  (e >= 31) ? 8'(e - 30) : 8'h00,
                  5'((e + 1) % 32), e >= 31);
        end

        // Tap changes, clamp, forwarding and recirculation.
        for (int i = 0; i < 9; i++) begin
            a_tap = vecs[i].tap;
            a_wr  = vecs[i].wr;
            a_d   = vecs[i].d;
            step();
            chk_a($sformatf("vec[%0d]", i), vecs[i].e_tap, vecs[i].e_last, vecs[i].e_slot, 1'b1);
        end

        // Write mask: slot 7 keeps its first-pass value.
        do_reset();
        a_tap = 6'd1;
        for (int s = 0; s < 32; s++) begin
            a_wr = 1'b1; a_d = 8'(8'hA0 + s);
            step();
        end
        for (int s = 0; s < 32; s++) begin
            a_wr = (s != 7); a_d = (s == 7) ? 8'hEE : 8'(8'hB0 + s);
            step();
        end
        for (int s = 0; s < 32; s++) begin
            a_wr = 1'b0; a_d = 8'h00;
            step();
            v = (s == 7) ? 8'hA7 : 8'(8'hB0 + s);
            chk($sformatf("mask_tap[%0d]", s), 32'(a_qtap), 32'(v));
            v = (((s + 1) % 32) == 7) ? 8'hA7 : 8'(8'hB0 + ((s + 1) % 32));
            chk($sformatf("mask_last[%0d]", s), 32'(a_qlast), 32'(v));
        end

        // Realign at wp=13.
        for (int s = 0; s < 13; s++) begin
            a_wr = 1'b1; a_d = 8'(8'h10 + s);
            step();
        end
        chk("pre_realign.slot", 32'(a_slot), 32'd13);
        a_tap = 6'd3; a_cntrrst = 1'b1; a_d = 8'h55;
        step();
        chk_a("realign0", 8'hCE, 8'h11, 5'd1, 1'b1);
        a_cntrrst = 1'b0; a_d = 8'h56;
        step();
        chk_a("realign1", 8'hCF, 8'h12, 5'd2, 1'b1);
        a_d = 8'h57;
        step();
        chk_a("realign2", 8'h55, 8'h13, 5'd3, 1'b1);

        // Clock-enable hold beats realign and write.
        a_cen_n = 1'b1; a_cntrrst = 1'b1; a_wr = 1'b1; a_d = 8'h99; a_tap = 6'd20;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_a($sformatf("hold[%0d]", k), 8'h55, 8'h13, 5'd3, 1'b1);
        end
        a_cen_n = 1'b0; a_cntrrst = 1'b0; a_wr = 1'b0; a_tap = 6'd1;
        step();
        chk_a("post_hold", 8'h13, 8'h14, 5'd4, 1'b1);

        // Asynchronous reset mid-cycle, then everything blanks.
        #3 rst = 1'b1;
        #1;
        chk_a("midrst", 8'h00, 8'h00, 5'd0, 1'b0);
        #1 rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_a($sformatf("postrst[%0d]", k), 8'h00, 8'h00, 5'(k), 1'b0);
        end

        // Non-power-of-two length.
        do_reset();
        b_cen_n = 1'b0; b_wr = 1'b1; b_tap = 5'd5;
        for (int e = 0; e < 30; e++) begin
            b_d = 8'(e + 1);
            step();
            chk($sformatf("np2_tap[%0d]", e),    32'(b_qtap),   (e >= 4)  ? 32'(e - 3)  : 32'd0);
            chk($sformatf("np2_last[%0d]", e),   32'(b_qlast),  (e >= 23) ? 32'(e - 22) : 32'd0);
            chk($sformatf("np2_slot[%0d]", e),   32'(b_slot),   32'((e + 1) % 24));
            chk($sformatf("np2_primed[%0d]", e), 32'(b_primed), (e >= 23) ? 32'd1 : 32'd0);
        end
        b_tap = 5'd24; b_d = 8'd31;
        step();
        chk("np2_t24.tap",  32'(b_qtap),  32'd8);
        chk("np2_t24.last", 32'(b_qlast), 32'd8);
        chk("np2_t24.slot", 32'(b_slot),  32'd7);
        b_tap = 5'd30; b_d = 8'd32;
        step();
        chk("np2_t30.tap",  32'(b_qtap),  32'd9);
        chk("np2_t30.last", 32'(b_qlast), 32'd9);
        chk("np2_t30.slot", 32'(b_slot),  32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/primitive_sr_bram_vtap.md
# primitive_sr_bram_vtap

BRAM-backed delay line with a runtime-selectable tap, a fixed last-stage output, per-slot write masking and output blanking of never-written slots. It is the parametrised successor to the fixed-tap BRAM shift register. It serves the 32-slot TDM operator/channel pipelines, where delay length must change at runtime (e.g. test modes or per-mode pipeline alignment) and must not leak stale power-on contents.

## Interface
- `WIDTH`, default 8: data width, 1..64.
- `LENGTH`, default 32: number of storage slots, 2..1024, not necessarily a power of two.
- Local constants:
  - `AW = clog2(LENGTH)`: pointer width.
  - `TW = clog2(LENGTH+1)`: tap-select width.
- Ports:
  - `i_EMUCLK`, in, 1: clock. All state changes on its rising edge.
  - `i_RST`, in, 1: reset, asynchronous, active-high.
  - `i_CEN_n`, in, 1: clock enable, active-low. An "enabled edge" is a rising edge with `i_CEN_n`=0.
  - `i_CNTRRST`, in, 1: synchronous pointer realign; the sample taken on this edge becomes slot 0.
  - `i_WR`, in, 1: write enable for the current slot.
  - `i_D`, in, `WIDTH`: write data.
  - `i_TAP`, in, `TW`: tap delay select, legal range 1..`LENGTH`.
  - `o_Q_TAP`, out, `WIDTH`: registered output at the selected tap.
  - `o_Q_LAST`, out, `WIDTH`: registered output at delay `LENGTH`.
  - `o_SLOT`, out, `AW`: current write pointer.
  - `o_PRIMED`, out, 1: high once `LENGTH` enabled edges have elapsed since reset.

## Operation
- Write pointer `wp` cycles 0..`LENGTH`-1 and wraps to 0. It advances on every enabled edge, regardless of `i_WR`.
- **Write:** on an enabled edge with `i_WR`=1, `mem[a] <= i_D` and `vld[a] <= 1`. The address `a` is `wp`, or 0 if `i_CNTRRST`=1.
  - With `i_WR`=0 the slot keeps its old content and old valid bit (recirculate).
- **Pointer update:** `wp <= (i_CNTRRST ? 0 : wp) + 1` modulo `LENGTH`.
- **Tap semantics:** identical to stage `TAP`-1 of a flip-flop shift register.
  - After enabled edge n, `o_Q_TAP` = slot value written at edge n-(T-1).
  - Read address = (a - (T-1)) mod `LENGTH`.
  - T=1 reads the slot being written on the same edge and returns the new `i_D` (write-first forwarding).
- **Tap clamp:** effective T = 1 if `i_TAP`=0; T = `LENGTH` if `i_TAP` > `LENGTH`.
- **Last output:** `o_Q_LAST` uses read address (a+1) mod `LENGTH`, i.e. fixed T=`LENGTH`.
- **Blanking:** an output reads as 0 when the `vld` bit of its source slot is 0.
- **Tap changes:** a change on `i_TAP` takes effect on the read at the next enabled edge. There is no glitch-free cross-fade.
- **Fill counter:** saturates at `LENGTH`; `o_PRIMED` = (fill == `LENGTH`). `i_CNTRRST` clears neither `fill` nor `vld`.
- **Priority:** `i_RST` > `i_CEN_n`=1 (hold everything; `i_CNTRRST`/`i_WR` ignored) > `i_CNTRRST` > normal advance.

## Timing
- Reset values:
  - `o_Q_TAP`=0, `o_Q_LAST`=0, `o_SLOT`=0, `o_PRIMED`=0.
  - `wp`=0, `fill`=0, all `vld`=0. Memory contents are not reset.
- Latency:
  - Data written at enabled edge e appears on `o_Q_TAP` after edge e+T-1 and holds for exactly one enabled cycle, unless re-read after `LENGTH` edges.
  - Data on `o_Q_LAST` appears after edge e+`LENGTH`-1.
- Both outputs are registered: they change only on enabled edges or asynchronously on `i_RST`.
- Wrap: `wp`=`LENGTH`-1 goes to 0. Read-address subtraction wraps modulo `LENGTH` (non-power-of-two safe; no bit truncation).
- `i_RST` asserted mid-stream: outputs clear immediately. After release, all reads blank to 0 until slots are rewritten.

## Structure
- Shared package/include `primitive_pkg` holds:
  - function `clog2`;
  - function `mod_sub(a, b, len)` for modulo-`LENGTH` subtraction.
- Sub-module `primitive_sdp_ram`: one write port, one registered read port, optional write-first bypass.
  - Instantiated twice (tap and last) with shared write signals.
- `vld` is a `LENGTH`-bit register vector held in fabric, because it needs an asynchronous clear.

## Test plan
- **Reset blanking:** `LENGTH`=32. After `i_RST`, run 40 enabled edges with `i_WR`=0 -> `o_Q_TAP`=`o_Q_LAST`=0 throughout; `o_PRIMED` rises after the 32nd edge.
- **Tap delay:** `i_TAP`=5. Write ramp 0x00,0x01,... -> `o_Q_TAP` lags the write data by 4 enabled edges; `o_Q_LAST` lags by 31. Check across the `wp` 31->0 wrap.
- **Clamp and forwarding:**
  - `i_TAP`=0 -> the sample written on an edge appears on `o_Q_TAP` after that same edge.
  - `i_TAP`=40 -> output equals `o_Q_LAST`.
- **Write mask:** fill slots with 0xA0+slot, then deassert `i_WR` for slot 7 only on the second pass -> the third-pass read of slot 7 returns 0xA7.
- **Realign:** pulse `i_CNTRRST` at `wp`=13 while writing 0x55 -> `o_SLOT`=1 after the edge; 0x55 appears at tap T after T-1 edges; `o_PRIMED` unchanged.
- **Enable/reset priority:**
  - `i_CEN_n`=1 for 10 clocks with `i_CNTRRST`=1 -> all outputs and `o_SLOT` frozen.
  - `i_RST` pulsed mid-cycle -> outputs 0 before the next clock edge.
- **Non-power-of-two:** `LENGTH`=24 -> `o_SLOT` sequence 0..23,0; tap arithmetic correct across the wrap.
